fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the IF/ID pipeline register.
- Consumes the ID-stage controller outputs pc_src, IFflush and the hazard unit stall.
- Drives a single-outstanding, variable-latency instruction-memory request and feeds fetched instructions to the decode stage.

Parameters:
- XLEN, 32, width of PC and instruction.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding written into IF/ID.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_src  in  2  from controller: 00 PC+4, 01 branch, 10 jump, 11 register (jr).
- if_flush  in  1  from controller: squash IF/ID.
- stall  in  1  load-use stall from hazard unit.
- branch_target  in  XLEN  ID-computed beq target.
- jump_index  in  26  instr[25:0] of the jump in ID.
- jr_target  in  XLEN  register value for jr.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_rdata  in  XLEN  instruction, valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- ifid_instr  out  XLEN  IF/ID instruction.
- ifid_pc_plus4  out  XLEN  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=FETCH, pend_pc=0, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, imem_req=0. imem_req=1 from the first cycle after rst deasserts. Reset mid-request abandons the request; memory must tolerate this.
- next_pc: 00 pc+4; 01 branch_target; 10 {ifid_pc_plus4[31:28], jump_index, 2'b00}; 11 jr_target. All adds wrap modulo 2^32.
- redirect = (pc_src != 00) && !stall. squash = (if_flush || pc_src != 00) && !stall.
- imem_addr = pc, always registered. It must stay stable while imem_req=1 && imem_ready=0.
- Priority at each edge: stall > redirect/squash > normal fetch.
  - stall=1: pc, IF/ID and state hold. pc_src and if_flush are ignored because the ID instruction re-evaluates next cycle. A memory response arriving with imem_ready=1 is dropped; the same pc is refetched.
- FETCH state:
  - imem_ready=1, no redirect, no stall: ifid_instr=imem_rdata, ifid_pc_plus4=pc+4, ifid_valid=1, pc=pc+4. Zero-wait throughput is 1 instr/cycle.
  - imem_ready=1 with redirect: IF/ID gets the bubble (NOP_INSTR, valid=0, pc_plus4 unchanged), pc=next_pc.
  - imem_ready=1 with squash only (if_flush, pc_src=00): bubble, pc=pc+4.
  - imem_ready=0, no redirect: IF/ID gets the bubble, pc holds.
  - imem_ready=0 with redirect: bubble, pend_pc=next_pc, state goes to DISCARD. The address must not change mid-request.
- DISCARD state:
  - imem_req stays 1 and imem_addr=pc (old address). IF/ID gets the bubble every cycle.
  - On imem_ready=1: data is dropped, pc=pend_pc, state goes to FETCH.
  - Further redirects while in DISCARD are impossible because the bubbles mean ID holds no control-flow instruction. If one occurs anyway, pend_pc is overwritten (last wins).
  - stall in DISCARD is ignored for the discard completion; IF/ID already holds a bubble.
- No combinational path from imem_rdata or imem_ready to imem_addr.

Decomposition:
- Shared package pipeline_pkg holds:
  - pc_src encodings: PC_PLUS4=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_JR=2'b11.
  - fetch_state_t {FETCH, DISCARD}.
  - NOP_INSTR.
- One combinational sub-module, next_pc_sel: pc_src, pc, ifid_pc_plus4, branch_target, jump_index, jr_target -> next_pc.

Test Plan:
- Reset, then zero-wait memory returning addr-as-data -> imem_addr 0,4,8,C on consecutive cycles. ifid_instr lags by one cycle; ifid_valid=1 from cycle 2.
- beq taken: pc_src=01, if_flush=1, branch_target=0x40, ready=1 -> IF/ID bubble, next imem_addr=0x40.
- Jump: ifid_pc_plus4=0x1000_0010, jump_index=0x000_0100, pc_src=10 -> next imem_addr=0x1000_0400.
- Wait states: imem_ready low for 3 cycles at pc=0x8 -> imem_addr holds 0x8, ifid_valid=0 for 3 cycles, then ifid_instr loaded and pc=0xC.
- Redirect during wait: jr_target=0x200, pc_src=11 while ready=0 at pc=0x10 -> addr holds 0x10 until ready; that data never reaches IF/ID; next addr=0x200.
- stall=1 with pc_src=01 for 2 cycles -> pc and IF/ID unchanged, redirect ignored. rst pulsed mid-wait -> pc=0, ifid_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: next-PC select codes, fetch FSM states and the bubble word.
package pipeline_pkg;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_JR     = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: sequential, beq target, j pseudo-direct target, or jr register.
module next_pc_sel
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] ifid_pc_plus4,
   input  logic [XLEN-1:0] branch_target,
   input  logic [25:0]     jump_index,
   input  logic [XLEN-1:0] jr_target,
   output logic [XLEN-1:0] next_pc
);

   logic [XLEN-1:0] jump_target;

   // Jump keeps the segment bits of the jump's own PC+4, not of the fetch PC.
   assign jump_target = {ifid_pc_plus4[XLEN-1 -: 4], jump_index, 2'b00};

   always_comb begin
      next_pc = pc + XLEN'(4);
      case (pc_src)
         PC_PLUS4:  next_pc = pc + XLEN'(4);
         PC_BRANCH: next_pc = branch_target;
         PC_JUMP:   next_pc = jump_target;
         PC_JR:     next_pc = jr_target;
         default:   next_pc = pc + XLEN'(4);
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request, IF/ID register.
// Redirects that arrive mid-request are parked in pend_pc until the old response drains.
module fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      pc_src,
   input  logic            if_flush,
   input  logic            stall,
   input  logic [XLEN-1:0] branch_target,
   input  logic [25:0]     jump_index,
   input  logic [XLEN-1:0] jr_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ready,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc_plus4,
   output logic            ifid_valid
);

   import pipeline_pkg::*;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic            valid_q, valid_d;
   logic            req_q;

   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] next_pc;
   logic            redirect;
   logic            squash;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign redirect = (pc_src != PC_PLUS4) && !stall;
   assign squash   = (if_flush || (pc_src != PC_PLUS4)) && !stall;

   next_pc_sel #(
      .XLEN(XLEN)
   ) u_next_pc_sel (
      .pc_src        (pc_src),
      .pc            (pc_q),
      .ifid_pc_plus4 (pc4_q),
      .branch_target (branch_target),
      .jump_index    (jump_index),
      .jr_target     (jr_target),
      .next_pc       (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: begin
            if (req_q && !imem_ready && redirect) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (imem_ready) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // Datapath next-state; nothing is accepted in the cycle before the first request goes out.
   always_comb begin
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      instr_d   = instr_q;
      pc4_d     = pc4_q;
      valid_d   = valid_q;
      if (req_q) begin
         case (state_q)
            FETCH: begin
               if (!stall) begin
                  if (imem_ready && !squash) begin
                     instr_d = imem_rdata;
                     pc4_d   = pc_plus4;
                     valid_d = 1'b1;
                  end else begin
                     instr_d = NOP_INSTR;
                     valid_d = 1'b0;
                  end
                  if (redirect) begin
                     if (imem_ready) begin
                        pc_d = next_pc;
                     end else begin
                        pend_pc_d = next_pc;
                     end
                  end else if (imem_ready) begin
                     pc_d = pc_plus4;
                  end
               end
            end
            DISCARD: begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               if (redirect) begin
                  pend_pc_d = next_pc;
               end
               if (imem_ready) begin
                  pc_d = redirect ? next_pc : pend_pc_q;
               end
            end
            default: begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         pend_pc_q <= '0;
         instr_q   <= NOP_INSTR;
         pc4_q     <= '0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         instr_q   <= instr_d;
         pc4_q     <= pc4_d;
         valid_q   <= valid_d;
         req_q     <= 1'b1;
      end
   end

   always_comb begin
      imem_req      = req_q;
      imem_addr     = pc_q;
      ifid_instr    = instr_q;
      ifid_pc_plus4 = pc4_q;
      ifid_valid    = valid_q;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns address XOR a tag so data is never zero.
module tb_fetch_stage;

   localparam logic [31:0] K = 32'hC0DE_0000;

   logic        clk;
   logic        rst;
   logic [1:0]  pc_src;
   logic        if_flush;
   logic        stall;
   logic [31:0] branch_target;
   logic [25:0] jump_index;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .pc_src        (pc_src),
      .if_flush      (if_flush),
      .stall         (stall),
      .branch_target (branch_target),
      .jump_index    (jump_index),
      .jr_target     (jr_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus4 (ifid_pc_plus4),
      .ifid_valid    (ifid_valid)
   );

   assign imem_rdata = imem_addr ^ K;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pc_src = 2'b00; if_flush = 1'b0; stall = 1'b0;
      branch_target = '0; jump_index = '0; jr_target = '0; imem_ready = 1'b1;
      step(); step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
      total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
      total++; if (ifid_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc_plus4); end
      $display("reset: req=%b addr=%h valid=%b", imem_req, imem_addr, ifid_valid);
      rst = 1'b0;
      step();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL first_valid got=%b exp=0", ifid_valid); end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         step();
         $display("seq: addr=%h instr=%h pc4=%h valid=%b", imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
         total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
         total++; if (ifid_instr !== (32'(4 * (i - 1)) ^ K)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, ifid_instr, 32'(4 * (i - 1)) ^ K); end
         total++; if (ifid_pc_plus4 !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, ifid_pc_plus4, 32'(4 * i)); end
         total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ifid_valid); end
      end
   endtask

   task automatic test_branch();
      pc_src = 2'b01; if_flush = 1'b1; branch_target = 32'h40;
      step();
      $display("branch: addr=%h valid=%b pc4=%h", imem_addr, ifid_valid, ifid_pc_plus4);
      total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL br_addr got=%h exp=00000040", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", ifid_valid); end
      total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL br_instr got=%h exp=0", ifid_instr); end
      total++; if (ifid_pc_plus4 !== 32'hC) begin bad++; $display("FAIL br_pc4 got=%h exp=0000000c", ifid_pc_plus4); end
      pc_src = 2'b00; if_flush = 1'b0;
      step();
      $display("branch_next: addr=%h instr=%h", imem_addr, ifid_instr);
      total++; if (imem_addr !== 32'h44) begin bad++; $display("FAIL br_next_addr got=%h exp=00000044", imem_addr); end
      total++; if (ifid_instr !== (32'h40 ^ K)) begin bad++; $display("FAIL br_next_instr got=%h exp=%h", ifid_instr, 32'h40 ^ K); end
   endtask

   task automatic test_jump();
      pc_src = 2'b11; jr_target = 32'h1000_000C;
      step();
      pc_src = 2'b00;
      step();
      total++; if (ifid_pc_plus4 !== 32'h1000_0010) begin bad++; $display("FAIL jmp_setup_pc4 got=%h exp=10000010", ifid_pc_plus4); end
      pc_src = 2'b10; jump_index = 26'h000_0100;
      step();
      $display("jump: addr=%h valid=%b", imem_addr, ifid_valid);
      total++; if (imem_addr !== 32'h1000_0400) begin bad++; $display("FAIL jmp_addr got=%h exp=10000400", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL jmp_valid got=%b exp=0", ifid_valid); end
      pc_src = 2'b00;
   endtask

   task automatic test_wait_states();
      pc_src = 2'b11; jr_target = 32'h8;
      step();
      pc_src = 2'b00; imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         $display("wait[%0d]: addr=%h valid=%b", i, imem_addr, ifid_valid);
         total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL wait_addr[%0d] got=%h exp=00000008", i, imem_addr); end
         total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL wait_valid[%0d] got=%b exp=0", i, ifid_valid); end
         total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req[%0d] got=%b exp=1", i, imem_req); end
      end
      imem_ready = 1'b1;
      step();
      $display("wait_done: addr=%h instr=%h pc4=%h", imem_addr, ifid_instr, ifid_pc_plus4);
      total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL wait_done_addr got=%h exp=0000000c", imem_addr); end
      total++; if (ifid_instr !== (32'h8 ^ K)) begin bad++; $display("FAIL wait_done_instr got=%h exp=%h", ifid_instr, 32'h8 ^ K); end
      total++; if (ifid_pc_plus4 !== 32'hC) begin bad++; $display("FAIL wait_done_pc4 got=%h exp=0000000c", ifid_pc_plus4); end
      total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL wait_done_valid got=%b exp=1", ifid_valid); end
      step();
   endtask

   task automatic test_redirect_wait();
      imem_ready = 1'b0; pc_src = 2'b11; jr_target = 32'h200;
      step();
      pc_src = 2'b00;
      step();
      $display("discard: addr=%h valid=%b", imem_addr, ifid_valid);
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL disc_addr got=%h exp=00000010", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL disc_valid got=%b exp=0", ifid_valid); end
      imem_ready = 1'b1;
      step();
      $display("discard_drop: addr=%h instr=%h valid=%b", imem_addr, ifid_instr, ifid_valid);
      total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL disc_redir_addr got=%h exp=00000200", imem_addr); end
      total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL disc_drop_instr got=%h exp=0", ifid_instr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL disc_drop_valid got=%b exp=0", ifid_valid); end
      step();
      total++; if (ifid_instr !== (32'h200 ^ K)) begin bad++; $display("FAIL disc_next_instr got=%h exp=%h", ifid_instr, 32'h200 ^ K); end
      total++; if (imem_addr !== 32'h204) begin bad++; $display("FAIL disc_next_addr got=%h exp=00000204", imem_addr); end
   endtask

   task automatic test_stall();
      stall = 1'b1; pc_src = 2'b01; branch_target = 32'h80;
      for (int i = 0; i < 2; i++) begin
         step();
         $display("stall[%0d]: addr=%h instr=%h valid=%b", i, imem_addr, ifid_instr, ifid_valid);
         total++; if (imem_addr !== 32'h204) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=00000204", i, imem_addr); end
         total++; if (ifid_instr !== (32'h200 ^ K)) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, ifid_instr, 32'h200 ^ K); end
         total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, ifid_valid); end
         total++; if (ifid_pc_plus4 !== 32'h204) begin bad++; $display("FAIL stall_pc4[%0d] got=%h exp=00000204", i, ifid_pc_plus4); end
      end
      stall = 1'b0; pc_src = 2'b00;
      step();
      total++; if (imem_addr !== 32'h208) begin bad++; $display("FAIL unstall_addr got=%h exp=00000208", imem_addr); end
      total++; if (ifid_instr !== (32'h204 ^ K)) begin bad++; $display("FAIL unstall_instr got=%h exp=%h", ifid_instr, 32'h204 ^ K); end
   endtask

   task automatic test_async_reset();
      imem_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      $display("async_rst: addr=%h valid=%b req=%b", imem_addr, ifid_valid, imem_req);
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h exp=0", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", ifid_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b exp=0", imem_req); end
      total++; if (ifid_pc_plus4 !== 32'h0) begin bad++; $display("FAIL arst_pc4 got=%h exp=0", ifid_pc_plus4); end
      step();
      rst = 1'b0;
      step();
      imem_ready = 1'b1;
      step();
      $display("post_rst: addr=%h instr=%h valid=%b", imem_addr, ifid_instr, ifid_valid);
      total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL post_rst_addr got=%h exp=00000004", imem_addr); end
      total++; if (ifid_instr !== K) begin bad++; $display("FAIL post_rst_instr got=%h exp=%h", ifid_instr, K); end
   endtask

   task automatic test_flush_only();
      if_flush = 1'b1;
      step();
      $display("flush: addr=%h valid=%b pc4=%h", imem_addr, ifid_valid, ifid_pc_plus4);
      total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL flush_addr got=%h exp=00000008", imem_addr); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ifid_valid); end
      total++; if (ifid_pc_plus4 !== 32'h4) begin bad++; $display("FAIL flush_pc4 got=%h exp=00000004", ifid_pc_plus4); end
      if_flush = 1'b0;
      step();
      total++; if (ifid_instr !== (32'h8 ^ K)) begin bad++; $display("FAIL flush_next_instr got=%h exp=%h", ifid_instr, 32'h8 ^ K); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_wait_states();
      test_redirect_wait();
      test_stall();
      test_async_reset();
      test_flush_only();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
